division_controller: RTL and testbench

//  Upstream sequencer for the iterative 8-bit divider (division module).
//  - Accepts dividend/divisor/tag from ALU decode over a valid/ready handshake.
//  - Screens divide-by-zero, pulses the divider wakeup and holds its operands stable.
//  - Waits for done, captures quotient/remainder and returns them over a valid/ready result port.
//  - Runs a watchdog so a stalled divider cannot hang the pipeline.

---
 rtl/division_controller.sv | 118 +++++++++++
 tb/tb_division_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/division_controller.sv
// Request sequencer for the iterative divider: screens divide-by-zero, issues the
// divider start pulse, waits for done under a watchdog, and returns the result.
module division_controller #(
   parameter int WIDTH   = 8,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_div_zero,
   output logic             out_timeout,
   output logic             div_hung,
   output logic [WIDTH-1:0] div_num1,
   output logic [WIDTH-1:0] div_num2,
   output logic             div_wakeup,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op_a, op_b, q_r, r_r;
   logic [TAG_W-1:0] tag_r;
   logic             dz_r, to_r, hung_r;
   logic [CNT_W-1:0] cnt;
   logic             accept, zero_div, done_hit, time_hit, resp_take;

   always_comb begin
      state_nxt = state;
      accept    = (state == IDLE) && in_valid && !hung_r;
      zero_div  = (in_divisor == '0);
      done_hit  = (state == WAIT) && div_done;
      // done has priority over an expiring watchdog in the same cycle
      time_hit  = (state == WAIT) && !div_done && (cnt == CNT_LAST);
      resp_take = (state == RESP) && out_ready;
      case (state)
         IDLE:    if (accept) state_nxt = zero_div ? RESP : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (done_hit || time_hit) state_nxt = RESP;
         RESP:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         op_a   <= '0;
         op_b   <= '0;
         tag_r  <= '0;
         q_r    <= '0;
         r_r    <= '0;
         dz_r   <= 1'b0;
         to_r   <= 1'b0;
         hung_r <= 1'b0;
         cnt    <= '0;
      end else begin
         if (accept) begin
            op_a  <= in_dividend;
            op_b  <= in_divisor;
            tag_r <= in_tag;
            if (zero_div) begin
               q_r  <= '1;
               r_r  <= in_dividend;
               dz_r <= 1'b1;
            end
         end
         if (state == ISSUE)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + CNT_W'(1);
         if (done_hit) begin
            q_r <= div_quotient;
            r_r <= div_remainder;
         end
         if (time_hit) begin
            q_r    <= '0;
            r_r    <= '0;
            to_r   <= 1'b1;
            hung_r <= 1'b1;
         end
         if (resp_take) begin
            dz_r <= 1'b0;
            to_r <= 1'b0;
         end
      end
   end

   assign in_ready      = (state == IDLE) && !hung_r;
   assign out_valid     = (state == RESP);
   assign out_quotient  = q_r;
   assign out_remainder = r_r;
   assign out_tag       = tag_r;
   assign out_div_zero  = dz_r;
   assign out_timeout   = to_r;
   assign div_hung      = hung_r;
   assign div_num1      = op_a;
   assign div_num2      = op_b;
   assign div_wakeup    = (state == ISSUE);

endmodule

// File: tb/tb_division_controller.sv
// Bench for division_controller: table-driven requests through a scoreboard, a stub
// divider with fixed latency, and hand sequences for backpressure, timeout and reset.
`timescale 1ns/1ps
module tb_division_controller;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] in_dividend = '0, in_divisor = '0;
   logic [3:0] in_tag = '0;
   logic       out_valid, out_ready = 1'b1;
   logic [7:0] out_quotient, out_remainder;
   logic [3:0] out_tag;
   logic       out_div_zero, out_timeout, div_hung;
   logic [7:0] div_num1, div_num2;
   logic       div_wakeup, div_done;
   logic [7:0] div_quotient, div_remainder;

   always #5 clk = ~clk;

   division_controller #(.WIDTH(8), .TAG_W(4), .TIMEOUT(64)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
      .out_div_zero(out_div_zero), .out_timeout(out_timeout), .div_hung(div_hung),
      .div_num1(div_num1), .div_num2(div_num2), .div_wakeup(div_wakeup),
      .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   // stub divider: done one cycle, 4 cycles after the wakeup pulse
   logic       stub_done, stub_hang = 1'b0, spur_done = 1'b0;
   logic [7:0] stub_q, stub_r;
   logic [2:0] stub_cnt;
   always @(posedge clk or posedge rstn) begin
      if (rstn) begin
         stub_cnt <= '0; stub_done <= 1'b0; stub_q <= '0; stub_r <= '0;
      end else begin
         stub_done <= 1'b0;
         if (div_wakeup) stub_cnt <= 3'd4;
         else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 3'd1;
            if (stub_cnt == 3'd1 && !stub_hang) begin
               stub_done <= 1'b1;
               stub_q <= (div_num2 != 0) ? div_num1 / div_num2 : 8'hFF;
               stub_r <= (div_num2 != 0) ? div_num1 % div_num2 : div_num1;
            end
         end
      end
   end
   assign div_done      = stub_done | spur_done;
   assign div_quotient  = stub_done ? stub_q : 8'hA5;
   assign div_remainder = stub_done ? stub_r : 8'h5A;

   typedef struct {
      logic [7:0] a, b;
      logic [3:0] tag;
      logic [7:0] q, r;
      logic       dz, to;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[10];
   int   n_vec = 0, n_err = 0, wake_seen = 0, exp_wake = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (div_wakeup) wake_seen++;
      if (out_valid) chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
         else begin
            vec_t e;
            e = sb.pop_front();
            chk("result{q,r,tag,dz,to}",
                {10'd0, out_quotient, out_remainder, out_tag, out_div_zero, out_timeout},
                {10'd0, e.q, e.r, e.tag, e.dz, e.to});
         end
      end
   end

   task automatic send(input vec_t v);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_dividend = v.a; in_divisor = v.b; in_tag = v.tag;
      sb.push_back(v);
      if (v.b != 0) exp_wake++;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (ok) begin
         @(posedge clk); #1;
      end else begin
         chk("accept_timeout", 32'd0, 32'd1);
         void'(sb.pop_back());
         if (v.b != 0) exp_wake--;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_empty", sb.size(), 32'd0);
   endtask

   function automatic vec_t mk(input logic [7:0] a, b, input logic [3:0] t,
                               input logic [7:0] q, r, input logic dz, to);
      vec_t v;
      v.a = a; v.b = b; v.tag = t; v.q = q; v.r = r; v.dz = dz; v.to = to;
      return v;
   endfunction

   initial begin
      logic [7:0] hq, hr;
      int         k, w0;

      tbl[0] = mk(8'd100, 8'd7,   4'd3,  8'd14,  8'd2,   1'b0, 1'b0);
      tbl[1] = mk(8'd255, 8'd1,   4'd1,  8'd255, 8'd0,   1'b0, 1'b0);
      tbl[2] = mk(8'd7,   8'd9,   4'd2,  8'd0,   8'd7,   1'b0, 1'b0);
      tbl[3] = mk(8'd5,   8'd0,   4'd4,  8'd255, 8'd5,   1'b1, 1'b0);
      tbl[4] = mk(8'd0,   8'd3,   4'd6,  8'd0,   8'd0,   1'b0, 1'b0);
      tbl[5] = mk(8'd255, 8'd255, 4'd7,  8'd1,   8'd0,   1'b0, 1'b0);
      tbl[6] = mk(8'd1,   8'd255, 4'd8,  8'd0,   8'd1,   1'b0, 1'b0);
      tbl[7] = mk(8'd128, 8'd0,   4'd15, 8'd255, 8'd128, 1'b1, 1'b0);
      tbl[8] = mk(8'd90,  8'd4,   4'd10, 8'd22,  8'd2,   1'b0, 1'b0);
      tbl[9] = mk(8'd0,   8'd0,   4'd0,  8'd255, 8'd0,   1'b1, 1'b0);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_zero_outs", {out_valid, out_quotient, out_remainder, out_tag, out_div_zero,
                            out_timeout, div_hung, div_num1, div_num2, div_wakeup}, 32'd0);
      rstn = 1'b0;

      // table, results back-to-back with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(tbl[i]);
      drain();

      // divide-by-zero bypass: out_valid directly after accept, no wakeup
      out_ready = 1'b0;
      w0 = wake_seen;
      send(mk(8'd5, 8'd0, 4'd9, 8'd255, 8'd5, 1'b1, 1'b0));
      chk("dz_valid_next_cycle", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      chk("dz_no_wakeup", wake_seen, w0);
      out_ready = 1'b1;
      drain();

      // backpressure: 200/13 held for 5 cycles
      out_ready = 1'b0;
      send(mk(8'd200, 8'd13, 4'd5, 8'd15, 8'd5, 1'b0, 1'b0));
      for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      hq = out_quotient; hr = out_remainder;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {16'd0, out_quotient, out_remainder}, {16'd0, 8'd15, 8'd5});
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      chk("bp_first_sample", {16'd0, hq, hr}, {16'd0, 8'd15, 8'd5});
      out_ready = 1'b1;
      drain();

      // spurious done outside WAIT is ignored
      @(posedge clk); #1 spur_done = 1'b1;
      @(posedge clk); #1 spur_done = 1'b0;
      @(negedge clk);
      chk("spur_no_valid", {30'd0, out_valid, in_ready}, 32'd1);

      // watchdog: stalled divider
      stub_hang = 1'b1;
      send(mk(8'd50, 8'd5, 4'd12, 8'd0, 8'd0, 1'b0, 1'b1));
      @(negedge clk);
      chk("to_wakeup_cycle", {31'd0, div_wakeup}, 32'd1);
      k = 0;
      for (int i = 1; i <= 100 && k == 0; i++) begin
         @(negedge clk);
         if (out_valid) k = i;
      end
      chk("to_wait_cycles", k, 32'd65);
      @(negedge clk);
      chk("to_hung", {30'd0, div_hung, in_ready}, 32'd2);
      w0 = wake_seen;
      @(posedge clk); #1;
      in_valid = 1'b1; in_dividend = 8'd9; in_divisor = 8'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hung_in_ready", {31'd0, in_ready}, 32'd0);
      end
      chk("hung_no_wakeup", wake_seen, w0);
      in_valid = 1'b0;
      rstn = 1'b1;
      #1 chk("hung_cleared", {30'd0, div_hung, in_ready}, 32'd1);
      @(negedge clk) rstn = 1'b0;
      stub_hang = 1'b0;

      // reset mid-WAIT abandons the request
      send(mk(8'd90, 8'd4, 4'd6, 8'd22, 8'd2, 1'b0, 1'b0));
      repeat (3) @(negedge clk);
      #2 rstn = 1'b1;
      #1 chk("midrst_outs", {28'd0, out_valid, in_ready, div_wakeup, (div_num1 != 0)}, 32'd4);
      sb.delete();
      @(negedge clk) rstn = 1'b0;
      repeat (20) @(negedge clk);
      send(mk(8'd90, 8'd4, 4'd6, 8'd22, 8'd2, 1'b0, 1'b0));
      drain();

      chk("wakeup_pulses", wake_seen, exp_wake);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
